// File: rtl/ambm_pkg.sv
// Shared definitions for the approximate Booth multiplier (ambm) accuracy-scoring blocks.
// Holds the operand/product widths, the scoring FSM state type and a saturating adder.
package ambm_pkg;

  localparam int unsigned OPW    = 16;
  localparam int unsigned PROD_W = 2 * OPW;
  localparam int unsigned SAT_W  = 64;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } state_e;

  // Adds two values of width w (w <= SAT_W) and clamps the result to all-ones in w bits.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned      w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ({{SAT_W{1'b0}}, 1'b1} << w) - {{SAT_W{1'b0}}, 1'b1};
    return (sum > lim) ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/ambm_err_calc.sv
// Combinational error terms for one approximate/exact product pair:
// signed difference, its magnitude and a mismatch flag.
module ambm_err_calc
  import ambm_pkg::*;
#(
  parameter int unsigned PW = PROD_W
) (
  input  logic [PW-1:0] approx_product,
  input  logic [PW-1:0] exact_product,
  output logic [PW:0]   diff,
  output logic [PW-1:0] err_abs,
  output logic          mismatch
);

  logic [PW:0] diff_neg;

  always_comb begin
    diff     = {1'b0, approx_product} - {1'b0, exact_product};
    diff_neg = -diff;
    // The magnitude of a PW+1-bit difference of two unsigned PW-bit values always fits in PW bits.
    err_abs  = diff[PW] ? diff_neg[PW-1:0] : diff[PW-1:0];
    mismatch = (err_abs != '0);
  end

endmodule

// File: rtl/ambm_err_stats.sv
// Windowed error statistics for the ambm multiplier: accepts NSAMP product pairs and
// accumulates absolute/signed error sums, maximum error and mismatch count.
module ambm_err_stats
  import ambm_pkg::*;
#(
  parameter int unsigned PW    = PROD_W,
  parameter int unsigned NSAMP = 63,
  parameter int unsigned SUMW  = 48,
  parameter int unsigned CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PW-1:0]   approx_product,
  input  logic [PW-1:0]   exact_product,
  output logic            busy,
  output logic            done,
  output logic [SUMW-1:0] err_abs_sum,
  output logic [SUMW-1:0] err_sgn_sum,
  output logic [PW-1:0]   err_max,
  output logic [CNTW-1:0] mismatch_cnt,
  output logic [CNTW-1:0] sample_cnt
);

  state_e state_q, state_d;

  logic            xfer;
  logic            last_xfer;
  logic            restart;

  logic [PW:0]     calc_diff;
  logic [PW-1:0]   calc_abs;
  logic            calc_mm;

  logic            s1_valid_q, s1_valid_d;
  logic [PW:0]     s1_diff_q, s1_diff_d;
  logic [PW-1:0]   s1_abs_q, s1_abs_d;
  logic            s1_mm_q, s1_mm_d;

  logic [SUMW-1:0] abs_sum_q, abs_sum_d;
  logic [SUMW-1:0] sgn_sum_q, sgn_sum_d;
  logic [PW-1:0]   max_q, max_d;
  logic [CNTW-1:0] mm_cnt_q, mm_cnt_d;
  logic [CNTW-1:0] smp_cnt_q, smp_cnt_d;

  ambm_err_calc #(
    .PW (PW)
  ) u_err_calc (
    .approx_product (approx_product),
    .exact_product  (exact_product),
    .diff           (calc_diff),
    .err_abs        (calc_abs),
    .mismatch       (calc_mm)
  );

  assign xfer      = in_valid & in_ready;
  assign last_xfer = xfer && (smp_cnt_q == CNTW'(NSAMP - 1));
  assign restart   = clear || ((state_q == StIdle) && start);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (start) state_d = StRun;
        StRun:   if (last_xfer) state_d = StFlush;
        StFlush: if (s1_valid_q) state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == StRun) && (smp_cnt_q < CNTW'(NSAMP));
    busy     = (state_q == StRun) || (state_q == StFlush);
    done     = (state_q == StDone);
  end

  // Datapath: stage 1 captures the error terms, stage 2 folds them into the accumulators.
  always_comb begin
    s1_valid_d = xfer;
    s1_diff_d  = s1_diff_q;
    s1_abs_d   = s1_abs_q;
    s1_mm_d    = s1_mm_q;
    abs_sum_d  = abs_sum_q;
    sgn_sum_d  = sgn_sum_q;
    max_d      = max_q;
    mm_cnt_d   = mm_cnt_q;
    smp_cnt_d  = smp_cnt_q;

    if (xfer) begin
      s1_diff_d = calc_diff;
      s1_abs_d  = calc_abs;
      s1_mm_d   = calc_mm;
      smp_cnt_d = smp_cnt_q + CNTW'(1);
    end

    if (s1_valid_q) begin
      abs_sum_d = SUMW'(sat_add(SAT_W'(abs_sum_q), SAT_W'(s1_abs_q), SUMW));
      sgn_sum_d = sgn_sum_q + SUMW'($signed(s1_diff_q));
      max_d     = (s1_abs_q > max_q) ? s1_abs_q : max_q;
      mm_cnt_d  = mm_cnt_q + CNTW'(s1_mm_q);
    end

    if (restart) begin
      s1_valid_d = 1'b0;
      s1_diff_d  = '0;
      s1_abs_d   = '0;
      s1_mm_d    = 1'b0;
      abs_sum_d  = '0;
      sgn_sum_d  = '0;
      max_d      = '0;
      mm_cnt_d   = '0;
      smp_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_diff_q  <= '0;
      s1_abs_q   <= '0;
      s1_mm_q    <= 1'b0;
      abs_sum_q  <= '0;
      sgn_sum_q  <= '0;
      max_q      <= '0;
      mm_cnt_q   <= '0;
      smp_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_diff_q  <= s1_diff_d;
      s1_abs_q   <= s1_abs_d;
      s1_mm_q    <= s1_mm_d;
      abs_sum_q  <= abs_sum_d;
      sgn_sum_q  <= sgn_sum_d;
      max_q      <= max_d;
      mm_cnt_q   <= mm_cnt_d;
      smp_cnt_q  <= smp_cnt_d;
    end
  end

  assign err_abs_sum  = abs_sum_q;
  assign err_sgn_sum  = sgn_sum_q;
  assign err_max      = max_q;
  assign mismatch_cnt = mm_cnt_q;
  assign sample_cnt   = smp_cnt_q;

endmodule

// File: tb/tb_ambm_err_stats.sv
// Directed bench for ambm_err_stats: three instances (NSAMP = 63, 4, 2) share the input bus
// and each is started independently.
module tb_ambm_err_stats;

  localparam int unsigned PW   = 32;
  localparam int unsigned SUMW = 48;
  localparam int unsigned CNTW = 16;

  logic          clk = 1'b0;
  logic          rst_n, clear, in_valid;
  logic [PW-1:0] approx, exact;
  logic          start_a, start_b, start_c;

  logic            rdy_a, busy_a, done_a, rdy_b, busy_b, done_b, rdy_c, busy_c, done_c;
  logic [SUMW-1:0] abs_a, sgn_a, abs_b, sgn_b, abs_c, sgn_c;
  logic [PW-1:0]   max_a, max_b, max_c;
  logic [CNTW-1:0] mm_a, cnt_a, mm_b, cnt_b, mm_c, cnt_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ambm_err_stats #(.PW(PW), .NSAMP(63), .SUMW(SUMW), .CNTW(CNTW)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .clear(clear), .in_valid(in_valid),
    .in_ready(rdy_a), .approx_product(approx), .exact_product(exact), .busy(busy_a),
    .done(done_a), .err_abs_sum(abs_a), .err_sgn_sum(sgn_a), .err_max(max_a),
    .mismatch_cnt(mm_a), .sample_cnt(cnt_a)
  );

  ambm_err_stats #(.PW(PW), .NSAMP(4), .SUMW(SUMW), .CNTW(CNTW)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .clear(clear), .in_valid(in_valid),
    .in_ready(rdy_b), .approx_product(approx), .exact_product(exact), .busy(busy_b),
    .done(done_b), .err_abs_sum(abs_b), .err_sgn_sum(sgn_b), .err_max(max_b),
    .mismatch_cnt(mm_b), .sample_cnt(cnt_b)
  );

  ambm_err_stats #(.PW(PW), .NSAMP(2), .SUMW(SUMW), .CNTW(CNTW)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .clear(clear), .in_valid(in_valid),
    .in_ready(rdy_c), .approx_product(approx), .exact_product(exact), .busy(busy_c),
    .done(done_c), .err_abs_sum(abs_c), .err_sgn_sum(sgn_c), .err_max(max_c),
    .mismatch_cnt(mm_c), .sample_cnt(cnt_c)
  );

  // Drives one pair with in_valid high and advances to the next falling edge.
  task automatic drive_pair(input logic [PW-1:0] a, input logic [PW-1:0] e);
    approx   = a;
    exact    = e;
    in_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; approx = '0; exact = '0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    #12;
    n_checks++;
    if ({rdy_a, busy_a, done_a} !== 3'b000) begin
      n_fail++; $display("FAIL reset ctrl: got %b want 000", {rdy_a, busy_a, done_a});
    end
    n_checks++;
    if ({abs_a, sgn_a, max_a, mm_a, cnt_a} !== '0) begin
      n_fail++; $display("FAIL reset results: got abs=%0d sgn=%0h max=%0d mm=%0d cnt=%0d want 0",
                         abs_a, sgn_a, max_a, mm_a, cnt_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_exact_window();
    int not_ready = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n_checks++;
    if ({busy_a, rdy_a, cnt_a} !== {1'b1, 1'b1, 16'd0}) begin
      n_fail++; $display("FAIL exact start: got busy=%b rdy=%b cnt=%0d want 1 1 0",
                         busy_a, rdy_a, cnt_a);
    end
    for (int i = 0; i < 63; i++) begin
      if (rdy_a !== 1'b1) not_ready++;
      drive_pair(32'(i * (i + 3)), 32'(i * (i + 3)));
    end
    in_valid = 1'b0;
    n_checks++;
    if (not_ready != 0) begin
      n_fail++; $display("FAIL exact in_ready: got %0d stalled cycles want 0", not_ready);
    end
    n_checks++;
    if ({rdy_a, done_a, busy_a, cnt_a} !== {1'b0, 1'b0, 1'b1, 16'd63}) begin
      n_fail++; $display("FAIL exact flush: got rdy=%b done=%b busy=%b cnt=%0d want 0 0 1 63",
                         rdy_a, done_a, busy_a, cnt_a);
    end
    @(negedge clk);
    n_checks++;
    if (done_a !== 1'b1) begin
      n_fail++; $display("FAIL exact done: got %b want 1", done_a);
    end
    n_checks++;
    if ({abs_a, sgn_a, max_a, mm_a, cnt_a} !== {96'd0, 32'd0, 16'd0, 16'd63}) begin
      n_fail++; $display("FAIL exact results: got abs=%0d sgn=%0h max=%0d mm=%0d cnt=%0d want 0 0 0 0 63",
                         abs_a, sgn_a, max_a, mm_a, cnt_a);
    end
    @(negedge clk);
    n_checks++;
    if ({done_a, busy_a} !== 2'b00) begin
      n_fail++; $display("FAIL exact idle: got done=%b busy=%b want 0 0", done_a, busy_a);
    end
  endtask

  task automatic test_mixed();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    drive_pair(32'd105, 32'd100);
    drive_pair(32'd93, 32'd100);
    drive_pair(32'd50, 32'd50);
    drive_pair(32'd3, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done_b !== 1'b1) begin
      n_fail++; $display("FAIL mixed done: got %b want 1", done_b);
    end
    n_checks++;
    if (abs_b !== 48'd15) begin
      n_fail++; $display("FAIL mixed abs: got %0d want 15", abs_b);
    end
    n_checks++;
    if (sgn_b !== 48'd1) begin
      n_fail++; $display("FAIL mixed sgn: got %0h want 1", sgn_b);
    end
    n_checks++;
    if ({max_b, mm_b, cnt_b} !== {32'd7, 16'd3, 16'd4}) begin
      n_fail++; $display("FAIL mixed max/mm/cnt: got %0d %0d %0d want 7 3 4", max_b, mm_b, cnt_b);
    end
    @(negedge clk);
  endtask

  task automatic test_extremes();
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    drive_pair(32'hFFFF_FFFF, 32'd0);
    n_checks++;
    if (abs_c !== 48'd0) begin
      n_fail++; $display("FAIL extreme latency: got abs=%0d want 0", abs_c);
    end
    drive_pair(32'd0, 32'hFFFF_FFFF);
    in_valid = 1'b0;
    n_checks++;
    if ({abs_c, sgn_c, max_c} !== {48'd4294967295, 48'd4294967295, 32'hFFFF_FFFF}) begin
      n_fail++; $display("FAIL extreme first: got abs=%0d sgn=%0h max=%0h want 4294967295 ffffffff ffffffff",
                         abs_c, sgn_c, max_c);
    end
    @(negedge clk);
    n_checks++;
    if (done_c !== 1'b1) begin
      n_fail++; $display("FAIL extreme done: got %b want 1", done_c);
    end
    n_checks++;
    if ({abs_c, sgn_c, max_c, mm_c} !== {48'd8589934590, 48'd0, 32'hFFFF_FFFF, 16'd2}) begin
      n_fail++; $display("FAIL extreme results: got abs=%0d sgn=%0h max=%0h mm=%0d want 8589934590 0 ffffffff 2",
                         abs_c, sgn_c, max_c, mm_c);
    end
    @(negedge clk);
  endtask

  task automatic test_handshake_gaps();
    logic [6:0] pat;
    int not_ready = 0;
    int ready_late = 0;
    int dones = 0;
    pat = 7'b1011001;  // bit j is in_valid for cycle j: 1,0,0,1,1,0,1
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int j = 0; j < 7; j++) begin
      if (rdy_b !== 1'b1) not_ready++;
      approx   = 32'(1001 + j);
      exact    = 32'(1000 + j);
      in_valid = pat[j];
      @(negedge clk);
    end
    n_checks++;
    if (not_ready != 0) begin
      n_fail++; $display("FAIL gaps in_ready: got %0d stalled cycles want 0", not_ready);
    end
    n_checks++;
    if ({rdy_b, cnt_b} !== {1'b0, 16'd4}) begin
      n_fail++; $display("FAIL gaps after 4th: got rdy=%b cnt=%0d want 0 4", rdy_b, cnt_b);
    end
    for (int j = 0; j < 3; j++) begin
      if (rdy_b !== 1'b0) ready_late++;
      drive_pair(32'(2100 + j), 32'(2000 + j));
      if (done_b === 1'b1) dones++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (ready_late != 0 || dones != 1) begin
      n_fail++; $display("FAIL gaps tail: got late_ready=%0d dones=%0d want 0 1", ready_late, dones);
    end
    n_checks++;
    if ({abs_b, max_b, mm_b, cnt_b} !== {48'd4, 32'd1, 16'd4, 16'd4}) begin
      n_fail++; $display("FAIL gaps results: got abs=%0d max=%0d mm=%0d cnt=%0d want 4 1 4 4",
                         abs_b, max_b, mm_b, cnt_b);
    end
  endtask

  task automatic test_controls();
    int bad_idle = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int j = 0; j < 3; j++) drive_pair(32'(7 * j + 2), 32'(7 * j));
    in_valid = 1'b0;
    start_a  = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n_checks++;
    if ({busy_a, rdy_a, cnt_a, abs_a, mm_a} !== {1'b1, 1'b1, 16'd3, 48'd6, 16'd3}) begin
      n_fail++; $display("FAIL start while busy: got busy=%b rdy=%b cnt=%0d abs=%0d mm=%0d want 1 1 3 6 3",
                         busy_a, rdy_a, cnt_a, abs_a, mm_a);
    end
    clear   = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    clear   = 1'b0;
    start_a = 1'b0;
    n_checks++;
    if ({busy_a, rdy_a, done_a} !== 3'b000) begin
      n_fail++; $display("FAIL clear ctrl: got busy=%b rdy=%b done=%b want 0 0 0", busy_a, rdy_a, done_a);
    end
    n_checks++;
    if ({abs_a, sgn_a, max_a, mm_a, cnt_a} !== '0) begin
      n_fail++; $display("FAIL clear results: got abs=%0d sgn=%0h max=%0d mm=%0d cnt=%0d want 0",
                         abs_a, sgn_a, max_a, mm_a, cnt_a);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (done_a !== 1'b0 || busy_a !== 1'b0) bad_idle++;
    end
    n_checks++;
    if (bad_idle != 0) begin
      n_fail++; $display("FAIL clear no done: got %0d bad cycles want 0", bad_idle);
    end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int j = 0; j < 63; j++) drive_pair(32'(j + 1), 32'(j));
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({done_a, abs_a, sgn_a, max_a, mm_a, cnt_a} !==
        {1'b1, 48'd63, 48'd63, 32'd1, 16'd63, 16'd63}) begin
      n_fail++; $display("FAIL fresh window: got done=%b abs=%0d sgn=%0h max=%0d mm=%0d cnt=%0d want 1 63 3f 1 63 63",
                         done_a, abs_a, sgn_a, max_a, mm_a, cnt_a);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    drive_pair(32'd13, 32'd10);
    drive_pair(32'd23, 32'd20);
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy_b, abs_b} !== {1'b1, 48'd6}) begin
      n_fail++; $display("FAIL pre-reset: got busy=%b abs=%0d want 1 6", busy_b, abs_b);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy_b, rdy_b, done_b, abs_b, sgn_b, max_b, mm_b, cnt_b} !== '0) begin
      n_fail++; $display("FAIL async reset: got busy=%b rdy=%b done=%b abs=%0d sgn=%0h max=%0d mm=%0d cnt=%0d want 0",
                         busy_b, rdy_b, done_b, abs_b, sgn_b, max_b, mm_b, cnt_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int j = 0; j < 4; j++) drive_pair(32'(10 * j), 32'(10 * j + 2));
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({done_b, abs_b, sgn_b, max_b, mm_b, cnt_b} !==
        {1'b1, 48'd8, 48'hFFFF_FFFF_FFF8, 32'd2, 16'd4, 16'd4}) begin
      n_fail++; $display("FAIL post-reset window: got done=%b abs=%0d sgn=%0h max=%0d mm=%0d cnt=%0d want 1 8 fffffffffff8 2 4 4",
                         done_b, abs_b, sgn_b, max_b, mm_b, cnt_b);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_exact_window();
    test_mixed();
    test_extremes();
    test_handshake_gaps();
    test_controls();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
